// File: rtl/key_sched_ctrl_pkg.sv
// Shared AES key-schedule definitions: encodings, per-key-length constants and the
// GF(2^8) xtime helper (also used by MixColumns).
package key_sched_ctrl_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2,
    KL_BAD = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    OP_XOR      = 2'd0,
    OP_ROT_RCON = 2'd1,
    OP_SUB      = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] RCON_POLY_DEF = 8'h1b;
  localparam logic [7:0] RCON_INIT     = 8'h01;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;

  localparam int W_128 = 44;
  localparam int W_192 = 52;
  localparam int W_256 = 60;

  function automatic logic [7:0] xtime(input logic [7:0] b, input logic [7:0] poly);
    return {b[6:0], 1'b0} ^ (b[7] ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/key_sched_ctrl_if.sv
// Step handshake between the AES control FSM, the key schedule controller and the
// key-expansion word datapath.
interface key_sched_ctrl_if #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 6
);

  logic              start;
  logic [1:0]        key_len;
  logic              ready;
  logic              valid;
  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        op;
  logic [WORD_W-1:0] rcon_word;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, key_len, ready,
    output valid, word_idx, op, rcon_word, busy, done, err
  );

  modport slave (
    output start, key_len, ready,
    input  valid, word_idx, op, rcon_word, busy, done, err
  );

endinterface

// File: rtl/key_sched_ctrl_rcon_gen.sv
// Round-constant register: reloads 01 at run start and advances by xtime after each
// accepted Rcon step.
module key_sched_ctrl_rcon_gen
  import key_sched_ctrl_pkg::*;
#(
  parameter logic [7:0] RCON_POLY = RCON_POLY_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       adv_i,
  output logic [7:0] rcon_o
);

  logic [7:0] rcon_q, rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    if (load_i) begin
      rcon_d = RCON_INIT;
    end else if (adv_i) begin
      rcon_d = xtime(rcon_q, RCON_POLY);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcon_q <= RCON_INIT;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon_o = rcon_q;

endmodule

// File: rtl/key_sched_ctrl.sv
// AES-128/192/256 key-expansion controller: walks word index Nk..W-1 and issues one
// transform descriptor per accepted handshake.
module key_sched_ctrl
  import key_sched_ctrl_pkg::*;
#(
  parameter int         WORD_W    = 32,
  parameter int         IDX_W     = 6,
  parameter logic [7:0] RCON_POLY = RCON_POLY_DEF
) (
  input logic              clk,
  input logic              rst_n,
  key_sched_ctrl_if.master bus
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [3:0]       nk_q, nk_d;
  logic [2:0]       k_q, k_d;
  logic             err_q, err_d;
  logic             rcon_load, rcon_adv;
  logic [7:0]       rcon;
  logic [1:0]       op;
  logic             run;

  assign run = (state_q == ST_RUN);

  // k is i mod Nk, tracked incrementally so no divider is needed.
  always_comb begin
    op = OP_XOR;
    if (run) begin
      if (k_q == 3'd0) begin
        op = OP_ROT_RCON;
      end else if ((nk_q == NK_256) && (k_q == 3'd4)) begin
        op = OP_SUB;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    nk_d      = nk_q;
    k_d       = k_q;
    err_d     = 1'b0;
    rcon_load = 1'b0;
    rcon_adv  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (key_len_e'(bus.key_len) == KL_BAD) begin
            err_d = 1'b1;
          end else begin
            unique case (key_len_e'(bus.key_len))
              KL_192: begin
                nk_d   = NK_192;
                last_d = IDX_W'(W_192 - 1);
              end
              KL_256: begin
                nk_d   = NK_256;
                last_d = IDX_W'(W_256 - 1);
              end
              default: begin
                nk_d   = NK_128;
                last_d = IDX_W'(W_128 - 1);
              end
            endcase
            idx_d     = IDX_W'(nk_d);
            k_d       = 3'd0;
            rcon_load = 1'b1;
            state_d   = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.ready) begin
          idx_d    = idx_q + IDX_W'(1);
          k_d      = ({1'b0, k_q} == (nk_q - 4'd1)) ? 3'd0 : (k_q + 3'd1);
          rcon_adv = (op == OP_ROT_RCON);
          if (idx_q == last_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      nk_q    <= NK_128;
      k_q     <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      nk_q    <= nk_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  key_sched_ctrl_rcon_gen #(
    .RCON_POLY(RCON_POLY)
  ) u_rcon_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(rcon_load),
    .adv_i (rcon_adv),
    .rcon_o(rcon)
  );

  assign bus.valid     = run;
  assign bus.busy      = run;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.err       = err_q;
  assign bus.word_idx  = run ? idx_q : '0;
  assign bus.op        = op;
  assign bus.rcon_word = (op == OP_ROT_RCON) ? {rcon, {(WORD_W - 8){1'b0}}} : '0;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: table of runs against a reference key-schedule model, plus
// illegal-length and mid-run reset sequences.
module tb_key_sched_ctrl;

  localparam int WORD_W = 32;
  localparam int IDX_W  = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_sched_ctrl_if #(.WORD_W(WORD_W), .IDX_W(IDX_W)) bus ();

  key_sched_ctrl #(
    .WORD_W   (WORD_W),
    .IDX_W    (IDX_W),
    .RCON_POLY(8'h1b)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int nvec = 0;
  int nmis = 0;

  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  typedef struct {
    logic [1:0] kl;
    bit         stall;
    bit         noise;
    int         exp_cyc;
  } run_t;

  run_t tbl [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic v, input logic b, input logic d,
                                       input logic e, input logic [5:0] idx,
                                       input logic [1:0] op, input logic [31:0] rw);
    return {20'h0, v, b, d, e, idx, op, rw};
  endfunction

  function automatic logic [63:0] obs_all();
    return pack(bus.valid, bus.busy, bus.done, bus.err, bus.word_idx, bus.op, bus.rcon_word);
  endfunction

  function automatic logic [63:0] obs_ctl();
    return {60'h0, bus.valid, bus.busy, bus.done, bus.err};
  endfunction

  // Reference: w[i] uses Rcon[i/Nk] when Nk divides i; AES-256 adds SubWord at i mod 8 == 4.
  function automatic logic [63:0] exp_step(input int nk, input int i);
    logic [1:0]  op;
    logic [31:0] rw;
    logic [5:0]  idx;
    op  = 2'd0;
    rw  = 32'h0;
    idx = i[5:0];
    if (i % nk == 0) begin
      op = 2'd1;
      rw = {rcon_tab[i / nk - 1], 24'h0};
    end else if (nk == 8 && i % 8 == 4) begin
      op = 2'd2;
    end
    return pack(1'b1, 1'b1, 1'b0, 1'b0, idx, op, rw);
  endfunction

  task automatic run(input logic [1:0] kl, input bit stall, input bit noise,
                     input int abort_idx, input int exp_cyc);
    int nk;
    int w;
    int i;
    int cyc;
    bit fin;
    nk  = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
    w   = 4 * nk + 28;
    i   = nk;
    cyc = 1;
    fin = 1'b0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.key_len = kl;
    bus.ready   = 1'b1;
    for (int c = 0; c < 600 && !fin; c++) begin
      @(negedge clk);
      cyc++;
      if (i < w) begin
        chk($sformatf("kl%0d_step_i%0d", kl, i), obs_all(), exp_step(nk, i));
        if (i == abort_idx) begin
          rst_n     = 1'b0;
          bus.start = 1'b0;
          fin       = 1'b1;
        end else begin
          bus.start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          bus.key_len = noise ? 2'($urandom_range(0, 3)) : kl;
          bus.ready   = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
          if (bus.ready) i++;
        end
      end else begin
        chk($sformatf("kl%0d_done_pulse", kl), obs_ctl(), 64'h2);
        if (exp_cyc != 0) chk($sformatf("kl%0d_cycles", kl), 64'(cyc), 64'(exp_cyc));
        bus.start = 1'b0;
        bus.ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk($sformatf("kl%0d_done_single", kl), obs_ctl(), 64'h0);
        fin = 1'b1;
      end
    end
    if (!fin) begin
      nvec++;
      nmis++;
      $display("FAIL kl%0d_timeout: got no done expected done within 600 cycles", kl);
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.key_len = 2'd0;
    bus.ready   = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", obs_all(), 64'h0);
    rst_n = 1'b1;

    tbl[0] = '{kl: 2'd0, stall: 1'b0, noise: 1'b0, exp_cyc: 42};
    tbl[1] = '{kl: 2'd1, stall: 1'b0, noise: 1'b0, exp_cyc: 48};
    tbl[2] = '{kl: 2'd2, stall: 1'b0, noise: 1'b0, exp_cyc: 54};
    tbl[3] = '{kl: 2'd0, stall: 1'b1, noise: 1'b1, exp_cyc: 0};
    tbl[4] = '{kl: 2'd2, stall: 1'b1, noise: 1'b1, exp_cyc: 0};
    for (int t = 0; t < 5; t++) begin
      run(tbl[t].kl, tbl[t].stall, tbl[t].noise, -1, tbl[t].exp_cyc);
    end

    // Illegal key length: one err pulse, controller stays idle.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.key_len = 2'd3;
    @(negedge clk);
    bus.start = 1'b0;
    chk("err_pulse", obs_ctl(), 64'h1);
    @(negedge clk);
    chk("err_single", obs_ctl(), 64'h0);

    // Reset in the middle of an AES-256 run, then a fresh AES-128 run.
    run(2'd2, 1'b0, 1'b0, 20, 0);
    @(negedge clk);
    chk("midrun_reset_state", obs_all(), 64'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_done_after_abort", obs_ctl(), 64'h0);
    end
    run(2'd0, 1'b0, 1'b0, -1, 42);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/key_sched_ctrl.md
# key_sched_ctrl

Sequential key-expansion controller for the AES datapath. It generates round constants on the fly (GF(2^8) xtime) instead of a fixed lookup, and supports AES-128/192/256 selected per run. It walks the expanded-key word index and tells the key-expansion datapath, one word per handshake, which transform to apply and which Rcon word to XOR. It sits between the top-level AES control FSM (start/done) and the key-expansion word datapath (valid/ready).

## Interface
Parameters:
- WORD_W, 32: expanded-key word width; Rcon byte placed in bits [WORD_W-1 -: 8], remainder zero.
- IDX_W, 6: width of word index; must hold 59.
- RCON_POLY, 8'h1b: reduction constant XORed by xtime on MSB overflow.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- key_len  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=illegal; sampled with start.
- ready  in  1  datapath accepts current step.
- valid  out  1  current step descriptor valid.
- word_idx  out  IDX_W  expanded-key index i of word being produced.
- op  out  2  0=XOR w[i-1] only, 1=RotWord+SubWord+Rcon, 2=SubWord only (AES-256).
- rcon_word  out  WORD_W  {rcon,0...} when op==1, else all zero.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after final step accepted.
- err  out  1  one-cycle pulse on start with key_len==3.

## Operation
- Config: Nk=4/6/8; total words W=44/52/60; steps i=Nk..W-1 (40/46/52 steps).
- States: IDLE, RUN, DONE.
  - IDLE: start & legal key_len -> RUN; latch Nk/W, i=Nk, phase counter k=0, rcon=8'h01.
  - IDLE: start & key_len==3 -> err=1 next cycle, stay IDLE.
  - RUN: valid=1. On valid&ready: i+=1; k=(k==Nk-1)?0:k+1 (no divider). If op==1, rcon=xtime(rcon).
  - RUN: accepted step with i==W-1 -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- op decode (combinational from k, Nk): k==0 -> 1; Nk==8 & k==4 -> 2; else 0.
- xtime: {rcon[6:0],1'b0} ^ (rcon[7] ? RCON_POLY : 0). The sequence must be 01,02,04,08,10,20,40,80,1b,36.
- start, key_len ignored outside IDLE. ready ignored when valid=0.

## Timing
- Reset values: valid=0, busy=0, done=0, err=0, op=0, word_idx=0, rcon_word=0, state=IDLE, rcon=8'h01.
- start at edge t -> valid=1, word_idx=Nk, op=1, rcon_word=32'h01000000 from cycle t+1.
- Throughput is one step per cycle with ready held high. A full AES-128 run is start -> done in 42 cycles.
- Backpressure: while valid&!ready, word_idx/op/rcon_word hold stable.
- Final handshake at edge t -> valid=0, done=1 in cycle t+1. A new start is accepted at earliest in cycle t+2 (IDLE).
- rst_n low at any edge: all state to reset values at that edge. A mid-run reset aborts without a done pulse.

## Structure
- Shared aes package: key_len encodings, op encodings, Nk/W constants per key length, RCON_POLY default, xtime function. The same xtime is reused by MixColumns.
- Sub-module rcon_gen: rcon register with load-01 and advance-by-xtime controls. Everything else stays in key_sched_ctrl.

## Test plan
- AES-128, ready=1: 40 valid steps i=4..43. op=1 exactly at i=4,8..40 with rcon bytes 01,02,04,08,10,20,40,80,1b,36. done is a single pulse.
- AES-192, ready=1: 46 steps i=6..51. op=1 at i=6,12..48 with rcon 01..80 (8 values). op never equals 2.
- AES-256: 52 steps i=8..59. op=1 at i=8,16..56 with rcon 01..40. op=2 at i=12,20..52 with rcon_word=0.
- Random ready stalls on AES-128: outputs hold while stalled. The accepted-step sequence matches the first test exactly. start pulses during RUN are ignored.
- start with key_len=3 -> err pulse next cycle, valid stays 0, busy stays 0.
- Reset asserted at AES-256 step i=20 -> next cycle all outputs at reset values, no done. A subsequent AES-128 run starts with rcon 01.
